// File: rtl/sbox_sched.sv
// rtl/sbox_sched.sv - shares one external 4-byte SubBytes unit between a 128-bit state job and a key-word job
// The slot is granted combinationally each cycle from the two busy flags; results are captured at the slot's end.
module sbox_sched #(
    parameter int unsigned KEY_PRIO = 1
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         st_start,
    input  logic [127:0] st_din,
    output logic         st_busy,
    output logic         st_done,
    output logic [127:0] st_dout,
    input  logic         kx_start,
    input  logic [31:0]  kx_din,
    output logic         kx_busy,
    output logic         kx_done,
    output logic [31:0]  kx_dout,
    output logic [31:0]  sb_x,
    input  logic [31:0]  sb_y,
    output logic [1:0]   sb_owner
);
    localparam logic [1:0] SLOT_IDLE = 2'd0;
    localparam logic [1:0] SLOT_KEY  = 2'd1;
    localparam logic [1:0] SLOT_COL  = 2'd2;

    logic         st_busy_q, st_busy_d;
    logic         st_done_q, st_done_d;
    logic [127:0] st_data_q, st_data_d;
    logic [127:0] st_dout_q, st_dout_d;
    logic [1:0]   col_q, col_d;
    logic         kx_busy_q, kx_busy_d;
    logic         kx_done_q, kx_done_d;
    logic [31:0]  kx_data_q, kx_data_d;
    logic [31:0]  kx_dout_q, kx_dout_d;
    logic [1:0]   slot;
    logic [31:0]  col_word;

    always_comb begin
        slot = SLOT_IDLE;
        if (kx_busy_q && ((KEY_PRIO != 0) || !st_busy_q)) begin
            slot = SLOT_KEY;
        end else if (st_busy_q) begin
            slot = SLOT_COL;
        end
    end

    always_comb begin
        col_word = st_data_q[127:96];
        case (col_q)
            2'd0:    col_word = st_data_q[127:96];
            2'd1:    col_word = st_data_q[95:64];
            2'd2:    col_word = st_data_q[63:32];
            default: col_word = st_data_q[31:0];
        endcase
    end

    always_comb begin
        sb_x = 32'h0;
        if (slot == SLOT_KEY) begin
            sb_x = kx_data_q;
        end else if (slot == SLOT_COL) begin
            sb_x = col_word;
        end
    end

    // A KEY slot leaves col untouched, so a preempted state job resumes at the same column.
    always_comb begin
        st_busy_d = st_busy_q;
        st_done_d = 1'b0;
        st_data_d = st_data_q;
        st_dout_d = st_dout_q;
        col_d     = col_q;
        kx_busy_d = kx_busy_q;
        kx_done_d = 1'b0;
        kx_data_d = kx_data_q;
        kx_dout_d = kx_dout_q;
        if (slot == SLOT_KEY) begin
            kx_dout_d = sb_y;
            kx_busy_d = 1'b0;
            kx_done_d = 1'b1;
        end else if (slot == SLOT_COL) begin
            case (col_q)
                2'd0:    st_dout_d[127:96] = sb_y;
                2'd1:    st_dout_d[95:64]  = sb_y;
                2'd2:    st_dout_d[63:32]  = sb_y;
                default: st_dout_d[31:0]   = sb_y;
            endcase
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
                st_busy_d = 1'b0;
                st_done_d = 1'b1;
            end
        end
        if (st_start && !st_busy_q) begin
            st_busy_d = 1'b1;
            st_data_d = st_din;
        end
        if (kx_start && !kx_busy_q) begin
            kx_busy_d = 1'b1;
            kx_data_d = kx_din;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            st_busy_q <= 1'b0;
            st_done_q <= 1'b0;
            st_data_q <= 128'h0;
            st_dout_q <= 128'h0;
            col_q     <= 2'd0;
            kx_busy_q <= 1'b0;
            kx_done_q <= 1'b0;
            kx_data_q <= 32'h0;
            kx_dout_q <= 32'h0;
        end else begin
            st_busy_q <= st_busy_d;
            st_done_q <= st_done_d;
            st_data_q <= st_data_d;
            st_dout_q <= st_dout_d;
            col_q     <= col_d;
            kx_busy_q <= kx_busy_d;
            kx_done_q <= kx_done_d;
            kx_data_q <= kx_data_d;
            kx_dout_q <= kx_dout_d;
        end
    end

    assign st_busy  = st_busy_q;
    assign st_done  = st_done_q;
    assign st_dout  = st_dout_q;
    assign kx_busy  = kx_busy_q;
    assign kx_done  = kx_done_q;
    assign kx_dout  = kx_dout_q;
    assign sb_owner = slot;

endmodule

// File: tb/tb_sbox_sched.sv
// tb/tb_sbox_sched.sv - bench for sbox_sched with both key priorities side by side
// Instance 0 uses KEY_PRIO=1, instance 1 uses KEY_PRIO=0; both see the same stimulus.
module tb_sbox_sched;
    typedef struct packed {
        int           cyc;
        logic [127:0] data;
    } exp_t;

    logic                CLK = 1'b0;
    logic                RSTn;
    logic                st_start, kx_start;
    logic [127:0]        st_din;
    logic [31:0]         kx_din;
    logic [1:0]          st_busy_w, st_done_w, kx_busy_w, kx_done_w;
    logic [1:0][127:0]   st_dout_w;
    logic [1:0][31:0]    kx_dout_w, sb_x_w, sb_y_w;
    logic [1:0][1:0]     sb_owner_w;

    int           cyc = 0;
    int           n_run = 0;
    int           n_fail = 0;
    logic         ending = 1'b0;
    logic         end_checked = 1'b0;
    exp_t         mq [4][$];
    exp_t         spq[4][$];
    logic         m_sb[2], m_kb[2];
    int           m_left[2];
    logic [127:0] m_sd[2];
    logic [31:0]  m_kd[2];
    logic [1:0]   eo;
    logic [31:0]  ex;
    logic         done_bit;
    logic [127:0] dout_v;
    exp_t         e;
    int           t;
    logic [127:0] d1, d2;
    logic [31:0]  kw;

    always #5 CLK = ~CLK;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // AES S-box from first principles: GF(2^8) inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, b;
        int         ee;
        r = 8'h01; b = a; ee = 254;
        while (ee != 0) begin
            if (ee[0]) r = gmul(r, b);
            b  = gmul(b, b);
            ee = ee >> 1;
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox(w[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox(s[8*k +: 8]);
        return r;
    endfunction

    assign sb_y_w[0] = sub_word(sb_x_w[0]);
    assign sb_y_w[1] = sub_word(sb_x_w[1]);

    sbox_sched #(.KEY_PRIO(1)) u_dut_p1 (
        .CLK(CLK), .RSTn(RSTn),
        .st_start(st_start), .st_din(st_din), .st_busy(st_busy_w[0]), .st_done(st_done_w[0]), .st_dout(st_dout_w[0]),
        .kx_start(kx_start), .kx_din(kx_din), .kx_busy(kx_busy_w[0]), .kx_done(kx_done_w[0]), .kx_dout(kx_dout_w[0]),
        .sb_x(sb_x_w[0]), .sb_y(sb_y_w[0]), .sb_owner(sb_owner_w[0])
    );

    sbox_sched #(.KEY_PRIO(0)) u_dut_p0 (
        .CLK(CLK), .RSTn(RSTn),
        .st_start(st_start), .st_din(st_din), .st_busy(st_busy_w[1]), .st_done(st_done_w[1]), .st_dout(st_dout_w[1]),
        .kx_start(kx_start), .kx_din(kx_din), .kx_busy(kx_busy_w[1]), .kx_done(kx_done_w[1]), .kx_dout(kx_dout_w[1]),
        .sb_x(sb_x_w[1]), .sb_y(sb_y_w[1]), .sb_owner(sb_owner_w[1])
    );

    // Reference model: pending jobs with a count of columns left; results computed whole at completion.
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < 2; i++) begin
                m_sb[i] = 1'b0; m_kb[i] = 1'b0; m_left[i] = 0; m_sd[i] = '0; m_kd[i] = '0;
            end
            for (int q = 0; q < 4; q++) mq[q].delete();
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                logic pre_s, pre_k;
                exp_t ne;
                pre_s = m_sb[i];
                pre_k = m_kb[i];
                if (pre_k && (i == 0 || !pre_s)) begin
                    ne.cyc = cyc; ne.data = {96'h0, sub_word(m_kd[i])};
                    mq[2*i].push_back(ne);
                    m_kb[i] = 1'b0;
                end else if (pre_s) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_sb[i] = 1'b0;
                        ne.cyc = cyc; ne.data = sub_state(m_sd[i]);
                        mq[2*i+1].push_back(ne);
                    end
                end
                if (st_start && !pre_s) begin
                    m_sb[i] = 1'b1; m_left[i] = 4; m_sd[i] = st_din;
                end
                if (kx_start && !pre_k) begin
                    m_kb[i] = 1'b1; m_kd[i] = kx_din;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < 2; i++) begin
                n_run++;
                if (st_busy_w[i] || st_done_w[i] || kx_busy_w[i] || kx_done_w[i] || st_dout_w[i] != 0 ||
                    kx_dout_w[i] != 0 || sb_x_w[i] != 0 || sb_owner_w[i] != 0) begin
                    n_fail++;
                    $display("FAIL reset_outputs inst%0d: st_busy=%b st_done=%b kx_busy=%b kx_done=%b owner=%0d sb_x=%h kx_dout=%h st_dout=%h, required all zero",
                             i, st_busy_w[i], st_done_w[i], kx_busy_w[i], kx_done_w[i], sb_owner_w[i], sb_x_w[i], kx_dout_w[i], st_dout_w[i]);
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                eo = 2'd0; ex = 32'h0;
                if (m_kb[i] && (i == 0 || !m_sb[i])) begin
                    eo = 2'd1; ex = m_kd[i];
                end else if (m_sb[i]) begin
                    eo = 2'd2; ex = m_sd[i][127 - 32*(4 - m_left[i]) -: 32];
                end
                n_run++;
                if (sb_owner_w[i] != eo || sb_x_w[i] != ex || st_busy_w[i] != m_sb[i] || kx_busy_w[i] != m_kb[i]) begin
                    n_fail++;
                    $display("FAIL slot inst%0d cyc%0d: owner=%0d sb_x=%h st_busy=%b kx_busy=%b, required owner=%0d sb_x=%h st_busy=%b kx_busy=%b",
                             i, cyc, sb_owner_w[i], sb_x_w[i], st_busy_w[i], kx_busy_w[i], eo, ex, m_sb[i], m_kb[i]);
                end
            end
            for (int q = 0; q < 4; q++) begin
                done_bit = (q % 2 == 1) ? st_done_w[q/2] : kx_done_w[q/2];
                dout_v   = (q % 2 == 1) ? st_dout_w[q/2] : {96'h0, kx_dout_w[q/2]};
                if (done_bit) begin
                    n_run++;
                    if (mq[q].size() == 0) begin
                        n_fail++;
                        $display("FAIL %s_done inst%0d: pulse at cyc%0d with data %h, required no pulse",
                                 (q % 2 == 1) ? "state" : "key", q/2, cyc, dout_v);
                    end else begin
                        e = mq[q].pop_front();
                        if (e.cyc != cyc || e.data != dout_v) begin
                            n_fail++;
                            $display("FAIL %s_done inst%0d: cyc%0d data %h, required cyc%0d data %h",
                                     (q % 2 == 1) ? "state" : "key", q/2, cyc, dout_v, e.cyc, e.data);
                        end
                    end
                    if (spq[q].size() != 0 && spq[q][0].cyc <= cyc) begin
                        e = spq[q].pop_front();
                        n_run++;
                        if (e.cyc != cyc || e.data != dout_v) begin
                            n_fail++;
                            $display("FAIL %s_directed inst%0d: cyc%0d data %h, required cyc%0d data %h",
                                     (q % 2 == 1) ? "state" : "key", q/2, cyc, dout_v, e.cyc, e.data);
                        end
                    end
                end
                while (mq[q].size() != 0 && mq[q][0].cyc < cyc) begin
                    e = mq[q].pop_front();
                    n_run++; n_fail++;
                    $display("FAIL %s_missed inst%0d: no pulse, required one at cyc%0d data %h",
                             (q % 2 == 1) ? "state" : "key", q/2, e.cyc, e.data);
                end
                while (spq[q].size() != 0 && spq[q][0].cyc < cyc) begin
                    e = spq[q].pop_front();
                    n_run++; n_fail++;
                    $display("FAIL %s_directed_missed inst%0d: no pulse, required one at cyc%0d data %h",
                             (q % 2 == 1) ? "state" : "key", q/2, e.cyc, e.data);
                end
            end
        end
        if (ending && !end_checked) begin
            end_checked = 1'b1;
            for (int q = 0; q < 4; q++) begin
                n_run++;
                if (mq[q].size() != 0 || spq[q].size() != 0) begin
                    n_fail++;
                    $display("FAIL drain q%0d: %0d model and %0d directed results pending, required 0",
                             q, mq[q].size(), spq[q].size());
                end
            end
        end
    end

    task automatic push_spec(input int q, input int c, input logic [127:0] d);
        exp_t ne;
        ne.cyc = c; ne.data = d;
        spq[q].push_back(ne);
    endtask

    // Queue index: 2*instance + (0 key, 1 state); a done stamp is the first cycle the pulse is visible.
    initial begin
        RSTn = 1'b0; st_start = 1'b0; st_din = '0; kx_start = 1'b0; kx_din = '0;
        repeat (3) @(negedge CLK);
        #1 RSTn = 1'b1;
        @(negedge CLK);

        kx_din = 32'h0; kx_start = 1'b1; t = cyc + 1;
        push_spec(0, t + 1, 128'h63636363);
        push_spec(2, t + 1, 128'h63636363);
        @(negedge CLK); kx_start = 1'b0;
        repeat (4) @(negedge CLK);

        st_din = 128'h00102030405060708090a0b0c0d0e0f0; st_start = 1'b1; t = cyc + 1;
        push_spec(1, t + 4, 128'h63cab7040953d051cd60e0e7ba70e18c);
        push_spec(3, t + 4, 128'h63cab7040953d051cd60e0e7ba70e18c);
        @(negedge CLK); st_start = 1'b0;
        repeat (6) @(negedge CLK);

        d1 = {$urandom, $urandom, $urandom, $urandom}; kw = $urandom;
        st_din = d1; st_start = 1'b1; t = cyc + 1;
        @(negedge CLK); st_start = 1'b0;
        @(negedge CLK); kx_din = kw; kx_start = 1'b1;
        push_spec(0, t + 3, {96'h0, sub_word(kw)});
        push_spec(1, t + 5, sub_state(d1));
        push_spec(2, t + 5, {96'h0, sub_word(kw)});
        push_spec(3, t + 4, sub_state(d1));
        @(negedge CLK); kx_start = 1'b0;
        repeat (7) @(negedge CLK);

        d1 = {$urandom, $urandom, $urandom, $urandom}; kw = $urandom;
        st_din = d1; st_start = 1'b1; kx_din = kw; kx_start = 1'b1; t = cyc + 1;
        push_spec(0, t + 1, {96'h0, sub_word(kw)});
        push_spec(1, t + 5, sub_state(d1));
        push_spec(2, t + 5, {96'h0, sub_word(kw)});
        push_spec(3, t + 4, sub_state(d1));
        @(negedge CLK); st_start = 1'b0; kx_start = 1'b0;
        repeat (8) @(negedge CLK);

        d1 = {$urandom, $urandom, $urandom, $urandom}; d2 = ~d1;
        st_din = d1; st_start = 1'b1; t = cyc + 1;
        push_spec(1, t + 4, sub_state(d1));
        push_spec(3, t + 4, sub_state(d1));
        @(negedge CLK); st_din = d2;
        @(negedge CLK); st_start = 1'b0;
        repeat (3) @(negedge CLK);
        d2 = {$urandom, $urandom, $urandom, $urandom};
        st_din = d2; st_start = 1'b1; t = cyc + 1;
        push_spec(1, t + 4, sub_state(d2));
        push_spec(3, t + 4, sub_state(d2));
        @(negedge CLK); st_start = 1'b0;
        repeat (7) @(negedge CLK);

        st_din = {$urandom, $urandom, $urandom, $urandom}; st_start = 1'b1;
        @(negedge CLK); st_start = 1'b0;
        @(negedge CLK);
        @(posedge CLK); #1 RSTn = 1'b0;
        @(negedge CLK); #1 RSTn = 1'b1;
        @(negedge CLK);
        d1 = {$urandom, $urandom, $urandom, $urandom};
        st_din = d1; st_start = 1'b1; t = cyc + 1;
        push_spec(1, t + 4, sub_state(d1));
        push_spec(3, t + 4, sub_state(d1));
        @(negedge CLK); st_start = 1'b0;
        repeat (6) @(negedge CLK);

        for (int n = 0; n < 600; n++) begin
            st_start = ($urandom_range(3) == 0);
            st_din   = {$urandom, $urandom, $urandom, $urandom};
            kx_start = ($urandom_range(2) == 0);
            kx_din   = $urandom;
            @(negedge CLK);
        end
        st_start = 1'b0; kx_start = 1'b0;
        repeat (12) @(negedge CLK);
        ending = 1'b1;
        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/sbox_sched.md
SBOX_SCHED -- requirements
Module: sbox_sched

Interface
REQ-001 SHALL have parameter KEY_PRIO, default 1, meaning 1 = a pending key word wins the shared slot over state columns and 0 = a pending key word waits until the state job completes.
REQ-002 SHALL have port CLK  in  1  the single clock; all state SHALL update on the rising edge.
REQ-003 SHALL have port RSTn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port st_start  in  1  a one-cycle strobe that starts a 128-bit state SubBytes job.
REQ-005 SHALL have port st_din  in  128  the state, where column i is st_din[127-32i -: 32].
REQ-006 SHALL have port st_busy  out  1  high while a state job is latched and not yet done.
REQ-007 SHALL have port st_done  out  1  a one-cycle pulse when st_dout becomes valid.
REQ-008 SHALL have port st_dout  out  128  the substituted state, with the same column order as st_din.
REQ-009 SHALL have port kx_start  in  1  a one-cycle strobe that starts a key-expansion SubWord job.
REQ-010 SHALL have port kx_din  in  32  the key word.
REQ-011 SHALL have port kx_busy  out  1  high while a key job is pending.
REQ-012 SHALL have port kx_done  out  1  a one-cycle pulse when kx_dout becomes valid.
REQ-013 SHALL have port kx_dout  out  32  the substituted key word.
REQ-014 SHALL have port sb_x  out  32  the operand to the shared external combinational 4-byte SubBytes unit.
REQ-015 SHALL have port sb_y  in  32  the result from that unit, valid in the same cycle as sb_x.
REQ-016 SHALL have port sb_owner  out  2  the slot owner: 0 = idle, 1 = key, 2 = state.

Function
REQ-017 SHALL latch st_din and set st_busy at the edge that samples st_start=1 with st_busy=0.
REQ-018 SHALL ignore st_start while st_busy=1.
REQ-019 SHALL latch kx_din and set kx_busy at the edge that samples kx_start=1 with kx_busy=0.
REQ-020 SHALL ignore kx_start while kx_busy=1.
REQ-021 SHALL use a slot scheduler with states IDLE, KEY and COL, plus a 2-bit column counter col (0..3).
REQ-022 SHALL grant each cycle KEY if kx_busy and (KEY_PRIO=1 or st_busy=0).
REQ-023 SHALL otherwise grant COL if st_busy.
REQ-024 SHALL otherwise be IDLE.
REQ-025 SHALL drive sb_x = 0 and sb_owner = 0 in IDLE.
REQ-026 SHALL drive sb_x = the latched key word and sb_owner = 1 in KEY.
REQ-027 SHALL, at the end of a KEY cycle, capture sb_y into kx_dout, clear kx_busy and pulse kx_done in the next cycle.
REQ-028 SHALL drive sb_x = latched column col and sb_owner = 2 in COL.
REQ-029 SHALL, at the end of a COL cycle, write sb_y into st_dout column col and increment col.
REQ-030 SHALL, when col=3 is written, wrap col to 0, clear st_busy and pulse st_done in the next cycle.
REQ-031 SHALL hold col unchanged during a KEY cycle that preempts a state job, so that the interrupted column resumes next.
REQ-032 SHALL give a key-only latency of 2 cycles (start edge t gives kx_done at cycle t+2) and a state-only latency of 5 cycles.
REQ-033 SHALL add exactly 1 cycle to the state latency for each interleaved KEY slot.
REQ-034 SHALL, on simultaneous st_start and kx_start from idle, issue KEY first and then COL0..3, with kx_done at t+2 and st_done at t+6 (KEY_PRIO=1).
REQ-035 SHALL accept a new start in the same cycle its done pulses, because busy is already low.
REQ-036 SHALL allow a new key job to preempt again between columns.
REQ-037 SHALL hold kx_dout and st_dout stable until overwritten by their own next job.
REQ-038 SHALL not expose partially written st_dout columns as valid; only st_done marks validity.

Reset
REQ-039 SHALL, on RSTn=0, immediately clear st_busy, kx_busy, st_done, kx_done, col, st_dout, kx_dout, sb_x and sb_owner to 0 and force state IDLE.
REQ-040 SHALL, on reset asserted mid-job, abandon the job with no done pulse, and SHALL accept starts from the first edge after RSTn returns high.

Verification
REQ-041 SHALL cover: kx_start with kx_din=32'h00000000 -> sb_owner=1 for one cycle, kx_done at t+2, kx_dout=32'h63636363.
REQ-042 SHALL cover: st_start with st_din=128'h00102030405060708090a0b0c0d0e0f0 -> four COL cycles, st_done at t+5, st_dout=128'h63cab7040953d051cd60e0e7ba70e18c.
REQ-043 SHALL cover: kx_start asserted during the COL1 cycle (KEY_PRIO=1) -> slot sequence COL0,COL1,KEY,COL2,COL3, kx_done correct, st_done delayed to t+6, st_dout unchanged in value.
REQ-044 SHALL cover: simultaneous starts with KEY_PRIO=0 -> COL0..3 then KEY, st_done at t+5, kx_done at t+6.
REQ-045 SHALL cover: st_start while st_busy=1 with different data -> ignored and the original result is returned; back-to-back start in the done cycle is accepted.
REQ-046 SHALL cover: RSTn pulsed low during COL2 -> all outputs are 0 immediately, no st_done, and a fresh job after release completes in 5 cycles.
